// File: rtl/dot_product_pkg.sv
// Shared types and widths for the dot-product datapath and its sequencer.
package dot_product_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_W = WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_e;

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Chunk input stream and result output stream of the sequencer.
interface dot_product_sequencer_if
    import dot_product_pkg::*;
#(
    parameter int N = 8
);

    logic                  in_valid;
    logic                  in_ready;
    logic [N*WORD_W-1:0]   in_a;
    logic [N*WORD_W-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_result;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/dot_product.sv
// Combinational N-lane dot product; lane products truncate to one word.
module dot_product
    import dot_product_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N*WORD_W-1:0] a,
    input  logic [N*WORD_W-1:0] b,
    output logic [WORD_W-1:0]   result
);

    logic [WORD_W-1:0] prod;

    always_comb begin
        result = '0;
        prod   = '0;
        for (int i = 0; i < N; i++) begin
            prod   = a[i*LANE_W +: LANE_W] * b[i*LANE_W +: LANE_W];
            result = result + prod;
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams chunk pairs through one registered dot_product stage and sums them.
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int N     = 8,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        num_chunks,
    input  logic                    abort,
    output logic                    busy,
    dot_product_sequencer_if.slave  s
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]   res_q, res_d;
    logic [N*WORD_W-1:0] a_q, a_d;
    logic [N*WORD_W-1:0] b_q, b_d;
    logic                sv_q, sv_d;
    logic [WORD_W-1:0]   partial;
    logic                accept;

    dot_product #(.N(N)) u_dp (
        .a      (a_q),
        .b      (b_q),
        .result (partial)
    );

    assign accept       = s.in_valid && (state_q == RUN);
    assign s.in_ready   = (state_q == RUN);
    assign s.out_valid  = (state_q == DONE);
    assign s.out_result = res_q;
    assign busy         = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sv_q    <= sv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        sv_d    = 1'b0;
        // Stage drains into acc on the same edge a new chunk may load.
        if (sv_q) acc_d = acc_q + partial;
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_chunks != '0) begin
                            rem_d   = num_chunks;
                            acc_d   = '0;
                            state_d = RUN;
                        end else begin
                            res_d   = '0;
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        a_d   = s.in_a;
                        b_d   = s.in_b;
                        sv_d  = 1'b1;
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    res_d   = acc_q + partial;
                    state_d = DONE;
                end
                DONE: begin
                    if (s.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed and randomized jobs checked against a whole-vector arithmetic model.
module tb_dot_product_sequencer;

    localparam int N     = 8;
    localparam int LEN_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] num_chunks;
    logic             abort;
    logic             busy;

    int checks = 0;
    int errors = 0;

    dot_product_sequencer_if #(.N(N)) bus ();

    dot_product_sequencer #(.N(N), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_chunks (num_chunks),
        .abort      (abort),
        .busy       (busy),
        .s          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: sum over lanes of a*b, all modulo 2^32.
    function automatic logic [31:0] chunk_dot(input logic [32*N-1:0] a,
                                              input logic [32*N-1:0] b);
        longint unsigned s = 0;
        for (int i = 0; i < N; i++)
            s += longint'(a[i*32 +: 32]) * longint'(b[i*32 +: 32]);
        return s[31:0];
    endfunction

    task automatic gen(input int mode, output logic [32*N-1:0] ca,
                       output logic [32*N-1:0] cb);
        for (int i = 0; i < N; i++) begin
            case (mode)
                1: begin ca[i*32 +: 32] = 32'd1; cb[i*32 +: 32] = 32'd2; end
                2: begin ca[i*32 +: 32] = 32'hFFFF_FFFF; cb[i*32 +: 32] = 32'd1; end
                3: begin ca[i*32 +: 32] = 32'(i + 1); cb[i*32 +: 32] = 32'd1; end
                4: begin ca[i*32 +: 32] = 32'd3; cb[i*32 +: 32] = 32'd3; end
                default: begin
                    ca[i*32 +: 32] = $urandom;
                    cb[i*32 +: 32] = $urandom;
                end
            endcase
        end
    endtask

    task automatic start_job(input int n);
        @(negedge clk);
        start      = 1'b1;
        num_chunks = LEN_W'(n);
    endtask

    task automatic feed(input int n, input int mode, input bit rv,
                        input int inj, output logic [31:0] sum);
        int got = 0;
        int cyc = 0;
        logic [32*N-1:0] ca, cb;
        sum = '0;
        gen(mode, ca, cb);
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start        = (cyc == inj);
            num_chunks   = (cyc == inj) ? LEN_W'(9) : LEN_W'(0);
            bus.in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_a     = ca;
            bus.in_b     = cb;
            if (bus.in_valid && bus.in_ready) begin
                got++;
                sum += chunk_dot(ca, cb);
                gen(mode, ca, cb);
            end
        end
        if (got < n) chk("feed_timeout", 32'(got), 32'(n));
    endtask

    task automatic check_done(input string tag, input logic [31:0] exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk({tag, "_ov_flush"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy_flush"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_res"}, bus.out_result, exp);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic drain(input string tag, input int stall);
        logic [31:0] held;
        held          = bus.out_result;
        bus.out_ready = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            chk({tag, "_stall_ov"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_stall_res"}, bus.out_result, held);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_ov"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] s;
        int          n;
        rst_n         = 1'b0;
        start         = 1'b0;
        num_chunks    = '0;
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_res", bus.out_result, 32'd0);
        rst_n = 1'b1;

        start_job(3);
        feed(3, 1, 1'b0, 0, s);
        check_done("basic", 32'h30);
        drain("basic", 0);

        start_job(0);
        @(negedge clk);
        start = 1'b0;
        chk("zero_ov", 32'(bus.out_valid), 32'd1);
        chk("zero_res", bus.out_result, 32'd0);
        chk("zero_rdy", 32'(bus.in_ready), 32'd0);
        drain("zero", 0);

        start_job(2);
        feed(2, 2, 1'b0, 0, s);
        check_done("wrap", 32'hFFFF_FFF0);
        drain("wrap", 0);

        start_job(4);
        feed(4, 3, 1'b1, 0, s);
        check_done("bp", 32'd144);
        drain("bp", 5);

        @(negedge clk);
        start      = 1'b1;
        abort      = 1'b1;
        num_chunks = LEN_W'(3);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);

        start_job(4);
        feed(2, 0, 1'b0, 0, s);
        @(negedge clk);
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdy", 32'(bus.in_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_ov", 32'(bus.out_valid), 32'd0);
        end
        start_job(1);
        feed(1, 4, 1'b0, 0, s);
        check_done("after_abort", 32'd72);
        drain("after_abort", 0);

        start_job(5);
        feed(5, 0, 1'b1, 2, s);
        check_done("busy_start", s);
        drain("busy_start", 1);

        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 6);
            start_job(n);
            feed(n, 0, 1'b1, 0, s);
            check_done("rand", s);
            drain("rand", $urandom_range(0, 3));
        end

        start_job(3);
        feed(1, 0, 1'b0, 0, s);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_res", bus.out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ov", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
